down_counter: RTL and testbench
===============================

# down_counter

Loadable down-counter/interval timer, the counterpart to the design's 8-bit enabled up-counter. Software or a controlling FSM loads a start value; the block decrements once per enabled clock and emits a one-cycle terminal-count pulse when the count expires. It either stops or auto-reloads to produce a periodic tick. It sits beside the up-counter in the counter library and drives timeouts and periodic strobes for neighbouring blocks.

## Interface
Parameters:
- WIDTH, 8, counter and load-value width in bits.
- RELOAD_EN, 0, 1 = auto-reload last loaded value on terminal count; 0 = stop in IDLE.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- load  input  1  load request; sampled every cycle.
- load_val  input  WIDTH  start value, captured when load=1.
- en  input  1  count enable; one decrement per cycle with en=1 in RUN.
- count  output  WIDTH  current count, registered.
- busy  output  1  high while in RUN.
- tc  output  1  terminal-count pulse, registered, exactly one cycle wide.

## Operation
- State machine with two states:
  - IDLE: count holds; en is ignored.
  - RUN: counting.
- Internal register reload_q (WIDTH bits) holds the last loaded value.
- Priority order per cycle: rst > load > count/terminal logic.
- rst: state=IDLE, count=0, reload_q=0, busy=0, tc=0.
- load=1, in any state:
  - count<=load_val and reload_q<=load_val.
  - load_val!=0: state<=RUN.
  - load_val==0: state<=IDLE.
  - tc<=0 in both cases.
- RUN, en=1, count>1: count<=count-1; tc<=0.
- RUN, en=1, count==1 (terminal):
  - tc<=1.
  - RELOAD_EN=1: count<=reload_q; remain in RUN.
  - RELOAD_EN=0: count<=0; state<=IDLE.
- RUN, en=0: count and state hold; tc<=0.
- IDLE, no load: count holds; tc<=0.
- busy is a registered decode of state==RUN.
- Arithmetic is unsigned WIDTH-bit. count never wraps below 0, because 0 is reachable only through terminal or load.
- load_val = 2^WIDTH-1 (255 at default width) is legal: 255 enabled cycles to tc.

## Timing
- Reset values: count=0, busy=0, tc=0.
- Load latency: 1 cycle. count shows load_val and busy=1 in the cycle after load=1.
- A load of N (N>=1) with en held high produces tc exactly N cycles after the first cycle in which busy=1 and count=N. tc is high in the same cycle count first shows 0 (no reload) or reload_q (reload).
- Auto-reload with en continuously high: tc period is exactly N cycles, with no dead cycle.
- load coincident with a terminal condition: load wins, tc stays 0, and the new value is taken.
- rst mid-RUN: next cycle is IDLE with count=0. No tc is generated, even if the count was 1.
- load_val=1, en=1: tc appears on the second cycle after load.
- busy falls in the same cycle tc rises (RELOAD_EN=0).

## Structure
- Shared package counter_pkg:
  - enum ctr_state_t {IDLE, RUN};
  - constant COUNT_W_DEFAULT = 8, shared with the up-counter.
- Single module with no sub-module. Next-state/next-count logic is one combinational block feeding one registered block (state, count, reload_q, tc, busy).

## Test plan
- Reset: assert rst for 2 cycles with load=1, load_val=8'h5A -> count=0, busy=0, tc=0 after release.
- One-shot: RELOAD_EN=0, load 3, en=1 -> count 3,2,1,0; tc high only on the 0 cycle; busy drops the same cycle; count stays 0 afterwards with en=1.
- Gated count: load 4, en toggling 1,0,1,0,... -> count decrements only on en=1 cycles; tc after the 4th enabled cycle; never during en=0.
- Auto-reload: RELOAD_EN=1, load 5, en=1 for 20 cycles -> tc every 5 cycles (4 pulses); count sequence 5,4,3,2,1,5,...
- Load collisions: load 0 -> IDLE, no tc. Load 9 coincident with count==1 and en=1 -> count=9, tc=0.
- Reset mid-run and max value: rst at count=1 -> no tc, count=0. Load 255, en=1 -> tc exactly 255 cycles later.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter library (up-counter and down-counter).
package counter_pkg;

    localparam int unsigned COUNT_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctr_state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter / interval timer with a one-cycle terminal-count pulse and
// optional auto-reload of the last loaded value.
module down_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = COUNT_W_DEFAULT,
    parameter bit          RELOAD_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    ctr_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            // A load overrides any terminal condition in the same cycle.
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (RELOAD_EN) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == RUN);
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed, table-driven bench for down_counter; one instance without and one with auto-reload.
module tb_down_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic [7:0] count0, count1;
    logic       busy0, busy1;
    logic       tc0, tc1;

    int n_vec;
    int n_bad;

    down_counter #(.WIDTH(8), .RELOAD_EN(1'b0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count0),
        .busy     (busy0),
        .tc       (tc0)
    );

    down_counter #(.WIDTH(8), .RELOAD_EN(1'b1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count1),
        .busy     (busy1),
        .tc       (tc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         sel;   // 0 checks the one-shot instance, 1 the reload instance
        logic       rst;
        logic       load;
        logic [7:0] val;
        logic       en;
        logic [7:0] cnt;
        logic       busy;
        logic       tc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, bit sel, logic r, logic l, logic [7:0] v, logic e,
                                logic [7:0] c, logic b, logic t);
        vec_t x;
        x.name = name; x.sel = sel; x.rst = r; x.load = l; x.val = v; x.en = e;
        x.cnt = c; x.busy = b; x.tc = t;
        vecs.push_back(x);
    endfunction

    // Applies inputs for one cycle, then checks the selected instance just after the edge.
    task automatic step(string name, bit sel, logic r, logic l, logic [7:0] v, logic e,
                        logic [7:0] c, logic b, logic t);
        logic [7:0] ac;
        logic       ab, at;
        rst = r; load = l; load_val = v; en = e;
        @(posedge clk);
        #1;
        ac = sel ? count1 : count0;
        ab = sel ? busy1  : busy0;
        at = sel ? tc1    : tc0;
        n_vec++;
        if (ac !== c) begin
            n_bad++;
            $display("FAIL %s count: got %0d, expected %0d", name, ac, c);
        end
        if (ab !== b) begin
            n_bad++;
            $display("FAIL %s busy: got %b, expected %b", name, ab, b);
        end
        if (at !== t) begin
            n_bad++;
            $display("FAIL %s tc: got %b, expected %b", name, at, t);
        end
    endtask

    initial begin
        int pulses;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0;

        //   name         sel rst ld val    en  cnt   busy tc
        add("reset0",     0, 1, 1, 8'h5A, 0, 8'd0, 0, 0);
        add("reset1",     0, 1, 1, 8'h5A, 0, 8'd0, 0, 0);
        add("post_rst",   0, 0, 0, 8'h00, 0, 8'd0, 0, 0);
        add("os_load3",   0, 0, 1, 8'd3,  1, 8'd3, 1, 0);
        add("os_2",       0, 0, 0, 8'd0,  1, 8'd2, 1, 0);
        add("os_1",       0, 0, 0, 8'd0,  1, 8'd1, 1, 0);
        add("os_tc",      0, 0, 0, 8'd0,  1, 8'd0, 0, 1);
        add("os_hold0",   0, 0, 0, 8'd0,  1, 8'd0, 0, 0);
        add("os_hold1",   0, 0, 0, 8'd0,  1, 8'd0, 0, 0);
        add("g_load4",    0, 0, 1, 8'd4,  0, 8'd4, 1, 0);
        add("g_e1",       0, 0, 0, 8'd0,  1, 8'd3, 1, 0);
        add("g_e0",       0, 0, 0, 8'd0,  0, 8'd3, 1, 0);
        add("g_e1b",      0, 0, 0, 8'd0,  1, 8'd2, 1, 0);
        add("g_e0b",      0, 0, 0, 8'd0,  0, 8'd2, 1, 0);
        add("g_e1c",      0, 0, 0, 8'd0,  1, 8'd1, 1, 0);
        add("g_e0c",      0, 0, 0, 8'd0,  0, 8'd1, 1, 0);
        add("g_tc",       0, 0, 0, 8'd0,  1, 8'd0, 0, 1);
        add("g_after",    0, 0, 0, 8'd0,  0, 8'd0, 0, 0);
        add("ld0",        0, 0, 1, 8'd0,  1, 8'd0, 0, 0);
        add("ld0_idle",   0, 0, 0, 8'd0,  1, 8'd0, 0, 0);
        add("col_load2",  0, 0, 1, 8'd2,  0, 8'd2, 1, 0);
        add("col_1",      0, 0, 0, 8'd0,  1, 8'd1, 1, 0);
        add("col_load9",  0, 0, 1, 8'd9,  1, 8'd9, 1, 0);
        add("col_8",      0, 0, 0, 8'd0,  1, 8'd8, 1, 0);
        add("mr_load2",   0, 0, 1, 8'd2,  0, 8'd2, 1, 0);
        add("mr_1",       0, 0, 0, 8'd0,  1, 8'd1, 1, 0);
        add("mr_rst",     0, 1, 0, 8'd0,  1, 8'd0, 0, 0);
        add("mr_after",   0, 0, 0, 8'd0,  1, 8'd0, 0, 0);
        add("ld1",        0, 0, 1, 8'd1,  1, 8'd1, 1, 0);
        add("ld1_tc",     0, 0, 0, 8'd0,  1, 8'd0, 0, 1);
        add("rl_col2",    1, 0, 1, 8'd2,  0, 8'd2, 1, 0);
        add("rl_col1",    1, 0, 0, 8'd0,  1, 8'd1, 1, 0);
        add("rl_col9",    1, 0, 1, 8'd9,  1, 8'd9, 1, 0);
        add("rl_col8",    1, 0, 0, 8'd0,  1, 8'd8, 1, 0);

        foreach (vecs[i])
            step(vecs[i].name, vecs[i].sel, vecs[i].rst, vecs[i].load, vecs[i].val,
                 vecs[i].en, vecs[i].cnt, vecs[i].busy, vecs[i].tc);

        // Auto-reload: load 5 then 20 enabled cycles; tc every 5th cycle, count 4,3,2,1,5,...
        pulses = 0;
        step("ar_load5", 1, 0, 1, 8'd5, 1, 8'd5, 1, 0);
        for (int i = 1; i <= 20; i++) begin
            step("ar_run", 1, 0, 0, 8'd0, 1, (i % 5 == 0) ? 8'd5 : 8'(5 - (i % 5)), 1,
                 (i % 5 == 0));
            if (tc1 === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 4) begin
            n_bad++;
            $display("FAIL ar_pulses: got %0d, expected 4", pulses);
        end

        // Maximum load: tc exactly 255 enabled cycles after count first shows 255.
        step("max_load", 0, 0, 1, 8'd255, 1, 8'd255, 1, 0);
        for (int i = 1; i < 255; i++)
            step("max_run", 0, 0, 0, 8'd0, 1, 8'(255 - i), 1, 0);
        step("max_tc", 0, 0, 0, 8'd0, 1, 8'd0, 0, 1);
        step("max_idle", 0, 0, 0, 8'd0, 1, 8'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
